cache_refill_engine: RTL and testbench

//  Miss-handling engine for one cache: writes back a dirty victim line, fetches the new line

---
 rtl/cache_refill_engine.sv | 196 +++++++++++++++++++
 tb/tb_cache_refill_engine.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_refill_engine.sv
// Miss-handling engine: optional dirty-victim writeback, line refill over the SRAM-style bus,
// and cache_table bank/tag/valid/dirty writes, with optional store merge on write misses.
module cache_refill_engine #(
    parameter  int NUM_WAY        = 2,
    parameter  int BYTES_PER_LINE = 16,
    parameter  int NUM_LINE       = 256,
    localparam int WORDS_PER_LINE = BYTES_PER_LINE / 4,
    localparam int BANK_NUM_WIDTH = $clog2(WORDS_PER_LINE),
    localparam int INDEX_WIDTH    = $clog2(NUM_LINE),
    localparam int OFFSET_WIDTH   = $clog2(BYTES_PER_LINE),
    localparam int TAG_WIDTH      = 32 - INDEX_WIDTH - OFFSET_WIDTH,
    localparam int BITS_PER_LINE  = BYTES_PER_LINE * 8
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [INDEX_WIDTH-1:0]    req_index,
    input  logic [TAG_WIDTH-1:0]      req_tag,
    input  logic [NUM_WAY-1:0]        req_way,
    input  logic                      victim_dirty,
    input  logic [TAG_WIDTH-1:0]      victim_tag,
    input  logic [BITS_PER_LINE-1:0]  victim_line,
    input  logic                      req_wr,
    input  logic [BANK_NUM_WIDTH-1:0] req_bank,
    input  logic [31:0]               req_wdata,
    input  logic [3:0]                req_wstrb,
    output logic                      done,
    output logic                      err,
    output logic                      rd_req,
    input  logic                      rd_rdy,
    output logic [2:0]                rd_type,
    output logic [31:0]               rd_addr,
    input  logic                      ret_valid,
    input  logic                      ret_last,
    input  logic [31:0]               ret_data,
    output logic                      wr_req,
    input  logic                      wr_rdy,
    output logic [2:0]                wr_type,
    output logic [31:0]               wr_addr,
    output logic [3:0]                wr_wstrb,
    output logic [BITS_PER_LINE-1:0]  wr_data,
    output logic                      write,
    output logic [NUM_WAY-1:0]        write_way,
    output logic [INDEX_WIDTH-1:0]    write_index,
    output logic [BANK_NUM_WIDTH-1:0] write_bank_num,
    output logic [31:0]               write_data,
    output logic [3:0]                write_strb,
    output logic [NUM_WAY-1:0]        tag_v_write_way,
    output logic [TAG_WIDTH-1:0]      tag_write,
    output logic                      v_write,
    output logic [NUM_WAY-1:0]        d_write_way,
    output logic                      d_write
);
    // Handshakes: a transfer happens on a cycle where both req/valid and rdy/ready are high;
    // the requester holds its request and payload stable until then.
    typedef enum logic [2:0] {IDLE, WB, RD, REFILL, DONE} state_t;

    state_t                    state_q, state_d;
    logic [BANK_NUM_WIDTH-1:0] cnt_q, cnt_d;
    logic                      err_q, err_d;
    logic [INDEX_WIDTH-1:0]    index_q;
    logic [TAG_WIDTH-1:0]      tag_q, vtag_q;
    logic [NUM_WAY-1:0]        way_q;
    logic [BITS_PER_LINE-1:0]  vline_q;
    logic                      wr_q;
    logic [BANK_NUM_WIDTH-1:0] bank_q;
    logic [31:0]               wdata_q;
    logic [3:0]                wstrb_q;
    logic [31:0]               mask;
    logic                      last_beat;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            index_q <= '0;
            tag_q   <= '0;
            vtag_q  <= '0;
            way_q   <= '0;
            vline_q <= '0;
            wr_q    <= 1'b0;
            bank_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            if (state_q == IDLE && req_valid) begin
                index_q <= req_index;
                tag_q   <= req_tag;
                vtag_q  <= victim_tag;
                way_q   <= req_way;
                vline_q <= victim_line;
                wr_q    <= req_wr;
                bank_q  <= req_bank;
                wdata_q <= req_wdata;
                wstrb_q <= req_wstrb;
            end
        end
    end

    always_comb begin
        for (int b = 0; b < 4; b++) begin
            mask[8*b +: 8] = {8{wstrb_q[b]}};
        end
    end

    assign last_beat = (cnt_q == BANK_NUM_WIDTH'(WORDS_PER_LINE - 1));
    assign err       = err_q;

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        err_d           = err_q;
        req_ready       = 1'b0;
        done            = 1'b0;
        rd_req          = 1'b0;
        rd_type         = 3'b000;
        rd_addr         = '0;
        wr_req          = 1'b0;
        wr_type         = 3'b000;
        wr_addr         = '0;
        wr_wstrb        = 4'h0;
        wr_data         = '0;
        write           = 1'b0;
        write_way       = '0;
        write_index     = '0;
        write_bank_num  = '0;
        write_data      = '0;
        write_strb      = 4'h0;
        tag_v_write_way = '0;
        tag_write       = '0;
        v_write         = 1'b0;
        d_write_way     = '0;
        d_write         = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_d = victim_dirty ? WB : RD;
            end
            WB: begin
                wr_req   = 1'b1;
                wr_type  = 3'b100;
                wr_wstrb = 4'hf;
                wr_addr  = {vtag_q, index_q, {OFFSET_WIDTH{1'b0}}};
                wr_data  = vline_q;
                if (wr_rdy) state_d = RD;
            end
            RD: begin
                rd_req  = 1'b1;
                rd_type = 3'b100;
                rd_addr = {tag_q, index_q, {OFFSET_WIDTH{1'b0}}};
                if (rd_rdy) begin
                    state_d = REFILL;
                    cnt_d   = '0;
                end
            end
            REFILL: begin
                if (ret_valid) begin
                    write          = 1'b1;
                    write_way      = way_q;
                    write_index    = index_q;
                    write_bank_num = cnt_q;
                    write_strb     = 4'hf;
                    write_data     = (wr_q && cnt_q == bank_q) ?
                                     ((wdata_q & mask) | (ret_data & ~mask)) : ret_data;
                    cnt_d          = cnt_q + 1'b1;
                    if (ret_last != last_beat) err_d = 1'b1;
                    // The line is invalidated on its first beat so an aborted refill never
                    // leaves a valid line with mixed old/new data.
                    if (cnt_q == '0) begin
                        tag_v_write_way = way_q;
                        tag_write       = tag_q;
                        v_write         = 1'b0;
                    end
                    if (last_beat) begin
                        tag_v_write_way = way_q;
                        tag_write       = tag_q;
                        v_write         = 1'b1;
                        d_write_way     = way_q;
                        d_write         = wr_q;
                        state_d         = DONE;
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_cache_refill_engine.sv
// Directed bench for cache_refill_engine: clean, dirty and write misses, gapped beats,
// ret_last protocol error and asynchronous reset during refill.
module tb_cache_refill_engine;
    logic         clk = 1'b0;
    logic         resetn;
    logic         req_valid, req_ready;
    logic [7:0]   req_index;
    logic [19:0]  req_tag;
    logic [1:0]   req_way;
    logic         victim_dirty;
    logic [19:0]  victim_tag;
    logic [127:0] victim_line;
    logic         req_wr;
    logic [1:0]   req_bank;
    logic [31:0]  req_wdata;
    logic [3:0]   req_wstrb;
    logic         done, err;
    logic         rd_req, rd_rdy;
    logic [2:0]   rd_type;
    logic [31:0]  rd_addr;
    logic         ret_valid, ret_last;
    logic [31:0]  ret_data;
    logic         wr_req, wr_rdy;
    logic [2:0]   wr_type;
    logic [31:0]  wr_addr;
    logic [3:0]   wr_wstrb;
    logic [127:0] wr_data;
    logic         write;
    logic [1:0]   write_way;
    logic [7:0]   write_index;
    logic [1:0]   write_bank_num;
    logic [31:0]  write_data;
    logic [3:0]   write_strb;
    logic [1:0]   tag_v_write_way;
    logic [19:0]  tag_write;
    logic         v_write;
    logic [1:0]   d_write_way;
    logic         d_write;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cache_refill_engine dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_index(req_index),
        .req_tag(req_tag), .req_way(req_way), .victim_dirty(victim_dirty),
        .victim_tag(victim_tag), .victim_line(victim_line), .req_wr(req_wr),
        .req_bank(req_bank), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .done(done), .err(err),
        .rd_req(rd_req), .rd_rdy(rd_rdy), .rd_type(rd_type), .rd_addr(rd_addr),
        .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
        .wr_req(wr_req), .wr_rdy(wr_rdy), .wr_type(wr_type), .wr_addr(wr_addr),
        .wr_wstrb(wr_wstrb), .wr_data(wr_data),
        .write(write), .write_way(write_way), .write_index(write_index),
        .write_bank_num(write_bank_num), .write_data(write_data), .write_strb(write_strb),
        .tag_v_write_way(tag_v_write_way), .tag_write(tag_write), .v_write(v_write),
        .d_write_way(d_write_way), .d_write(d_write)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one miss request for a single cycle while the engine is idle.
    task automatic send_req(input logic [7:0] idx, input logic [19:0] tag, input logic [1:0] way,
                            input logic dirty, input logic [19:0] vtag, input logic [127:0] vline,
                            input logic wr, input logic [1:0] bank, input logic [31:0] wdata,
                            input logic [3:0] wstrb);
        req_index = idx; req_tag = tag; req_way = way; victim_dirty = dirty;
        victim_tag = vtag; victim_line = vline; req_wr = wr; req_bank = bank;
        req_wdata = wdata; req_wstrb = wstrb; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic grant_rd();
        rd_rdy = 1'b1;
        tick();
        rd_rdy = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        req_valid = 0; req_index = 0; req_tag = 0; req_way = 0; victim_dirty = 0;
        victim_tag = 0; victim_line = '0; req_wr = 0; req_bank = 0; req_wdata = 0;
        req_wstrb = 0; rd_rdy = 0; wr_rdy = 0; ret_valid = 0; ret_last = 0; ret_data = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({req_ready, done, err, rd_req, wr_req, write, v_write, d_write} !== 8'b1000_0000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b exp 10000000",
                     {req_ready, done, err, rd_req, wr_req, write, v_write, d_write});
        end
        checks++;
        if ({rd_addr, wr_addr, write_data} !== 96'd0) begin
            errors++;
            $display("FAIL reset_data: got %h exp 0", {rd_addr, wr_addr, write_data});
        end
        @(negedge clk);
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_clean_miss();
        send_req(8'd5, 20'h12345, 2'b01, 1'b0, 20'h0, '0, 1'b0, 2'd0, 32'h0, 4'h0);
        checks++;
        if ({rd_req, rd_type, rd_addr, wr_req, req_ready} !== {1'b1, 3'b100, 32'h12345050, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL clean_rd_req: got %b %b %h %b %b exp 1 100 12345050 0 0",
                     rd_req, rd_type, rd_addr, wr_req, req_ready);
        end
        grant_rd();
        for (int i = 0; i < 4; i++) begin
            ret_valid = 1'b1; ret_data = 32'hA0 + i; ret_last = (i == 3);
            #1;
            checks++;
            if ({write, write_way, write_index, write_bank_num, write_data, write_strb} !==
                {1'b1, 2'b01, 8'd5, 2'(i), 32'hA0 + i, 4'hf}) begin
                errors++;
                $display("FAIL clean_bank%0d: got %b %b %h %0d %h %h", i, write, write_way,
                         write_index, write_bank_num, write_data, write_strb);
            end
            checks++;
            if ({tag_v_write_way, tag_write, v_write, d_write_way, d_write} !==
                {(i == 0 || i == 3) ? 2'b01 : 2'b00, (i == 0 || i == 3) ? 20'h12345 : 20'h0,
                 i == 3, i == 3 ? 2'b01 : 2'b00, 1'b0}) begin
                errors++;
                $display("FAIL clean_tagv%0d: got way=%b tag=%h v=%b dway=%b d=%b", i,
                         tag_v_write_way, tag_write, v_write, d_write_way, d_write);
            end
            tick();
        end
        ret_valid = 1'b0; ret_last = 1'b0;
        #1;
        checks++;
        if ({done, write, wr_req, err} !== 4'b1000) begin
            errors++;
            $display("FAIL clean_done: got %b exp 1000", {done, write, wr_req, err});
        end
        tick();
        checks++;
        if ({done, req_ready} !== 2'b01) begin
            errors++;
            $display("FAIL clean_idle: got %b exp 01", {done, req_ready});
        end
    endtask

    task automatic test_dirty_miss();
        logic [127:0] line;
        line = 128'h0123456789ABCDEF_FEDCBA9876543210;
        send_req(8'd9, 20'h00ABC, 2'b10, 1'b1, 20'h00777, line, 1'b0, 2'd0, 32'h0, 4'h0);
        victim_line = ~line;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++;
            if ({wr_req, wr_type, wr_wstrb, wr_addr, wr_data, rd_req} !==
                {1'b1, 3'b100, 4'hf, 32'h00777090, line, 1'b0}) begin
                errors++;
                $display("FAIL dirty_wb_hold%0d: got req=%b addr=%h data=%h rd=%b", k,
                         wr_req, wr_addr, wr_data, rd_req);
            end
            tick();
        end
        wr_rdy = 1'b1;
        tick();
        wr_rdy = 1'b0;
        #1;
        checks++;
        if ({wr_req, rd_req, rd_addr} !== {1'b0, 1'b1, 32'h00ABC090}) begin
            errors++;
            $display("FAIL dirty_rd_after_wb: got %b %b %h exp 0 1 00abc090", wr_req, rd_req, rd_addr);
        end
        grant_rd();
        for (int i = 0; i < 4; i++) begin
            ret_valid = 1'b1; ret_data = 32'hC0 + i; ret_last = (i == 3);
            #1;
            checks++;
            if ({write, write_way, write_index, write_bank_num, write_data} !==
                {1'b1, 2'b10, 8'd9, 2'(i), 32'hC0 + i}) begin
                errors++;
                $display("FAIL dirty_bank%0d: got %b %b %h %0d %h", i, write, write_way,
                         write_index, write_bank_num, write_data);
            end
            tick();
        end
        ret_valid = 1'b0; ret_last = 1'b0;
        #1;
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL dirty_done: got %b exp 1", done);
        end
        tick();
    endtask

    task automatic test_write_miss();
        send_req(8'd3, 20'h55555, 2'b10, 1'b0, 20'h0, '0, 1'b1, 2'd2, 32'hDEADBEEF, 4'b0011);
        grant_rd();
        for (int i = 0; i < 4; i++) begin
            ret_valid = 1'b1; ret_data = 32'h11223344; ret_last = (i == 3);
            #1;
            checks++;
            if (write_data !== ((i == 2) ? 32'h1122BEEF : 32'h11223344)) begin
                errors++;
                $display("FAIL wmiss_bank%0d: got %h exp %h", i, write_data,
                         (i == 2) ? 32'h1122BEEF : 32'h11223344);
            end
            if (i == 3) begin
                checks++;
                if ({v_write, tag_v_write_way, d_write, d_write_way} !== {1'b1, 2'b10, 1'b1, 2'b10}) begin
                    errors++;
                    $display("FAIL wmiss_dirty: got v=%b tvw=%b d=%b dw=%b exp 1 10 1 10",
                             v_write, tag_v_write_way, d_write, d_write_way);
                end
            end
            tick();
        end
        ret_valid = 1'b0; ret_last = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_gapped_beats();
        send_req(8'd7, 20'h0F0F0, 2'b01, 1'b0, 20'h0, '0, 1'b0, 2'd0, 32'h0, 4'h0);
        grant_rd();
        for (int i = 0; i < 4; i++) begin
            ret_valid = 1'b1; ret_data = 32'hB0 + i; ret_last = (i == 3);
            #1;
            checks++;
            if ({write, write_bank_num, write_data} !== {1'b1, 2'(i), 32'hB0 + i}) begin
                errors++;
                $display("FAIL gap_beat%0d: got %b %0d %h", i, write, write_bank_num, write_data);
            end
            tick();
            if (i < 3) begin
                ret_valid = 1'b0; ret_data = 32'hFFFF_FFFF; ret_last = 1'b1;
                #1;
                checks++;
                if ({write, done} !== 2'b00) begin
                    errors++;
                    $display("FAIL gap_idle%0d: got %b exp 00", i, {write, done});
                end
                tick();
            end
        end
        ret_valid = 1'b0; ret_last = 1'b0;
        #1;
        checks++;
        if ({done, err} !== 2'b10) begin
            errors++;
            $display("FAIL gap_done: got %b exp 10", {done, err});
        end
        tick();
    endtask

    task automatic test_ret_last_err();
        send_req(8'd1, 20'h00042, 2'b01, 1'b0, 20'h0, '0, 1'b0, 2'd0, 32'h0, 4'h0);
        grant_rd();
        for (int i = 0; i < 4; i++) begin
            ret_valid = 1'b1; ret_data = 32'hE0 + i; ret_last = (i == 1);
            tick();
            checks++;
            if (err !== (i >= 1)) begin
                errors++;
                $display("FAIL err_after_beat%0d: got %b exp %b", i, err, i >= 1);
            end
        end
        ret_valid = 1'b0; ret_last = 1'b0;
        #1;
        checks++;
        if ({done, err} !== 2'b11) begin
            errors++;
            $display("FAIL err_done: got %b exp 11", {done, err});
        end
        tick();
        checks++;
        if ({req_ready, err} !== 2'b11) begin
            errors++;
            $display("FAIL err_sticky: got %b exp 11", {req_ready, err});
        end
    endtask

    task automatic test_reset_in_refill();
        send_req(8'd2, 20'h0AAAA, 2'b10, 1'b0, 20'h0, '0, 1'b0, 2'd0, 32'h0, 4'h0);
        grant_rd();
        for (int i = 0; i < 2; i++) begin
            ret_valid = 1'b1; ret_data = 32'hD0 + i; ret_last = 1'b0;
            tick();
        end
        ret_valid = 1'b1; ret_data = 32'hD2;
        #1;
        checks++;
        if ({write, write_bank_num} !== {1'b1, 2'd2}) begin
            errors++;
            $display("FAIL rst_pre_beat2: got %b %0d exp 1 2", write, write_bank_num);
        end
        resetn = 1'b0;
        #1;
        checks++;
        if ({write, v_write, tag_v_write_way, done, err, rd_req, wr_req, write_data} !==
            {1'b1 ^ 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL rst_async: got w=%b v=%b tvw=%b done=%b err=%b rd=%b wr=%b wd=%h",
                     write, v_write, tag_v_write_way, done, err, rd_req, wr_req, write_data);
        end
        ret_valid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        tick();
        checks++;
        if ({req_ready, write, done} !== 3'b100) begin
            errors++;
            $display("FAIL rst_release: got %b exp 100", {req_ready, write, done});
        end
    endtask

    initial begin
        test_reset();
        test_clean_miss();
        test_dirty_miss();
        test_write_miss();
        test_gapped_beats();
        test_ret_last_err();
        test_reset_in_refill();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
